// File: rtl/wb_commit_monitor.sv
// Writeback commit monitor: stamps each register-file commit with a cycle count and queues it in a fall-through FIFO.
// Latency: a commit sampled at edge N is at the head after edge N. When full, a commit is dropped unless a pop happens in the same cycle.
// Defining WB_COMMIT_MONITOR_SHADOW_EN adds a 32x32 shadow register file that can be read combinationally.
module wb_commit_monitor #(
  parameter int DEPTH = 8,
  parameter int CYC_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_write_addr_5,
  input  logic [31:0]      wb_write_data_32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_addr_5,
  output logic [31:0]      out_data_32,
  output logic [CYC_W-1:0] out_cycle,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CNT_W-1:0] commit_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  input  logic [4:0]       shadow_addr_5,
  output logic [31:0]      shadow_data_32
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      occ;
  logic [4:0]       mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [CYC_W-1:0] mem_cyc  [DEPTH];

  logic commit, full, pop, push, drop;

  assign commit = wb_reg_write && (wb_write_addr_5 != 5'd0);
  assign full   = (occ == OCC_FULL);
  assign pop    = out_valid && out_ready;
  // A full FIFO can still take a commit when the head leaves in the same cycle.
  assign push   = commit && (!full || pop);
  assign drop   = commit && full && !pop;

  assign out_valid   = (occ != '0);
  assign out_addr_5  = out_valid ? mem_addr[rd_ptr] : 5'd0;
  assign out_data_32 = out_valid ? mem_data[rd_ptr] : 32'd0;
  assign out_cycle   = out_valid ? mem_cyc[rd_ptr]  : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occ          <= '0;
      cycle_count  <= '0;
      commit_count <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      cycle_count <= cycle_count + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (push && (commit_count != '1)) commit_count <= commit_count + 1'b1;
      if (drop) begin
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
        overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; only the pointers decide what is visible.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_addr[wr_ptr] <= wb_write_addr_5;
      mem_data[wr_ptr] <= wb_write_data_32;
      mem_cyc[wr_ptr]  <= cycle_count;
    end
  end

`ifdef WB_COMMIT_MONITOR_SHADOW_EN
  logic [31:0] shadow [32];

  // Dropped commits still update the shadow: it tracks architectural state, not the queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 32'd0;
    end else if (commit) begin
      shadow[wb_write_addr_5] <= wb_write_data_32;
    end
  end

  assign shadow_data_32 = (shadow_addr_5 == 5'd0) ? 32'd0 : shadow[shadow_addr_5];
`else
  logic shadow_unused;
  assign shadow_unused  = ^shadow_addr_5;
  assign shadow_data_32 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_commit_monitor.sv
// Directed self-checking bench for wb_commit_monitor (default parameters).
module tb_wb_commit_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_reg_write;
  logic [4:0]  wb_write_addr_5;
  logic [31:0] wb_write_data_32;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr_5;
  logic [31:0] out_data_32;
  logic [15:0] out_cycle;
  logic [15:0] cycle_count;
  logic [15:0] commit_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic [4:0]  shadow_addr_5;
  logic [31:0] shadow_data_32;

  int n_cmp = 0;
  int n_err = 0;

  wb_commit_monitor #(.DEPTH(8), .CYC_W(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .wb_reg_write(wb_reg_write), .wb_write_addr_5(wb_write_addr_5),
    .wb_write_data_32(wb_write_data_32),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr_5(out_addr_5), .out_data_32(out_data_32), .out_cycle(out_cycle),
    .cycle_count(cycle_count), .commit_count(commit_count),
    .drop_count(drop_count), .overflow(overflow),
    .shadow_addr_5(shadow_addr_5), .shadow_data_32(shadow_data_32)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_commit(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_reg_write = we;
    wb_write_addr_5 = a;
    wb_write_data_32 = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_commit(1'b0, 5'd0, 32'd0);
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL reset_cycle0: got %0d want 0", cycle_count); end
    repeat (5) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_addr_5 !== 5'd0 || out_data_32 !== 32'd0 || out_cycle !== 16'd0) begin n_err++; $display("FAIL reset_head: got %0d %h %0d want 0 0 0", out_addr_5, out_data_32, out_cycle); end
    n_cmp++; if (cycle_count !== 16'd5) begin n_err++; $display("FAIL reset_cycle5: got %0d want 5", cycle_count); end
    n_cmp++; if (commit_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_counters: got %0d %0d %b want 0 0 0", commit_count, drop_count, overflow); end
  endtask

  task automatic test_single_commit();
    do_reset();
    repeat (3) tick();
    n_cmp++; if (cycle_count !== 16'd3) begin n_err++; $display("FAIL single_precycle: got %0d want 3", cycle_count); end
    set_commit(1'b1, 5'd16, 32'h0000_0005);
    tick();
    set_commit(1'b0, 5'd0, 32'd0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_addr_5 !== 5'd16 || out_data_32 !== 32'h5 || out_cycle !== 16'd3) begin n_err++; $display("FAIL single_head: got %0d %h %0d want 16 00000005 3", out_addr_5, out_data_32, out_cycle); end
    n_cmp++; if (commit_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", commit_count); end
  endtask

  task automatic test_zero_write();
    do_reset();
    set_commit(1'b1, 5'd0, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    tick();
    tick();
    set_commit(1'b0, 5'd0, 32'd0);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid: got %b want 0", out_valid); end
    n_cmp++; if (commit_count !== 16'd0 || drop_count !== 16'd0) begin n_err++; $display("FAIL zero_counts: got %0d %0d want 0 0", commit_count, drop_count); end
    // RegWrite low with a nonzero address is not a commit either
    set_commit(1'b0, 5'd7, 32'h1);
    tick();
    set_commit(1'b0, 5'd0, 32'd0);
    n_cmp++; if (out_valid !== 1'b0 || commit_count !== 16'd0) begin n_err++; $display("FAIL nowrite_ignored: got %b %0d want 0 0", out_valid, commit_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 8; i <= 16; i++) begin
      set_commit(1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
    end
    set_commit(1'b0, 5'd0, 32'd0);
    n_cmp++; if (drop_count !== 16'd1 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_drop: got %0d %b want 1 1", drop_count, overflow); end
    n_cmp++; if (commit_count !== 16'd8) begin n_err++; $display("FAIL ovf_commits: got %0d want 8", commit_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_addr_5 !== 5'(8 + i) || out_data_32 !== (32'h108 + 32'(i)) || out_cycle !== 16'(i)) begin
        n_err++; $display("FAIL ovf_drain[%0d]: got v=%b %0d %h %0d want 1 %0d %h %0d", i, out_valid, out_addr_5, out_data_32, out_cycle, 8 + i, 32'h108 + 32'(i), i);
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_data_32 !== 32'd0) begin n_err++; $display("FAIL ovf_empty: got %b %h want 0 0", out_valid, out_data_32); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_pop_and_reset();
    logic [4:0] exp_a [9];
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      set_commit(1'b1, 5'(i), 32'hA000_0000 + 32'(i));
      tick();
    end
    // Full: commit and pop together
    set_commit(1'b1, 5'd20, 32'hABCD_0020);
    out_ready = 1'b1;
    n_cmp++; if (out_addr_5 !== 5'd1) begin n_err++; $display("FAIL full_head_before: got %0d want 1", out_addr_5); end
    tick();
    n_cmp++; if (drop_count !== 16'd0 || commit_count !== 16'd9 || out_addr_5 !== 5'd2) begin n_err++; $display("FAIL full_pushpop: got drop=%0d commits=%0d head=%0d want 0 9 2", drop_count, commit_count, out_addr_5); end
    // Still full: a lone commit must be dropped
    set_commit(1'b1, 5'd21, 32'hDEAD_0021);
    out_ready = 1'b0;
    tick();
    set_commit(1'b0, 5'd0, 32'd0);
    n_cmp++; if (drop_count !== 16'd1 || overflow !== 1'b1 || commit_count !== 16'd9) begin n_err++; $display("FAIL full_still: got drop=%0d ovf=%b commits=%0d want 1 1 9", drop_count, overflow, commit_count); end
    exp_a = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd20, 5'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_addr_5 !== exp_a[i] || out_cycle !== ((i == 7) ? 16'd8 : 16'(i + 1))) begin
        n_err++; $display("FAIL full_drain[%0d]: got v=%b %0d cyc=%0d want 1 %0d", i, out_valid, out_addr_5, out_cycle, exp_a[i]);
      end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drain_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
    set_commit(1'b1, 5'd3, 32'h3);
    tick();
    set_commit(1'b1, 5'd4, 32'h4);
    tick();
    // Reset wins over a simultaneous commit
    reset = 1'b1;
    set_commit(1'b1, 5'd5, 32'h5);
    tick();
    reset = 1'b0;
    set_commit(1'b0, 5'd0, 32'd0);
    n_cmp++; if (out_valid !== 1'b0 || commit_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0 || cycle_count !== 16'd0) begin
      n_err++; $display("FAIL midreset: got v=%b c=%0d d=%0d o=%b cyc=%0d want 0 0 0 0 0", out_valid, commit_count, drop_count, overflow, cycle_count);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || cycle_count !== 16'd1) begin n_err++; $display("FAIL midreset_after: got v=%b cyc=%0d want 0 1", out_valid, cycle_count); end
  endtask

  task automatic test_back_to_back();
    // Push and pop on every cycle from a one-entry queue
    do_reset();
    set_commit(1'b1, 5'd1, 32'h11);
    tick();
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      set_commit(1'b1, 5'(i), 32'h10 + 32'(i - 1) * 32'h1 + 32'h0);
      n_cmp++; if (out_addr_5 !== 5'(i - 1) || out_cycle !== 16'(i - 2)) begin n_err++; $display("FAIL b2b[%0d]: got %0d cyc=%0d want %0d %0d", i, out_addr_5, out_cycle, i - 1, i - 2); end
      tick();
    end
    set_commit(1'b0, 5'd0, 32'd0);
    n_cmp++; if (out_addr_5 !== 5'd4 || commit_count !== 16'd4) begin n_err++; $display("FAIL b2b_last: got %0d %0d want 4 4", out_addr_5, commit_count); end
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_shadow();
    logic [31:0] exp17;
`ifdef WB_COMMIT_MONITOR_SHADOW_EN
    exp17 = 32'h1234_ABCD;
`else
    exp17 = 32'h0;
`endif
    do_reset();
    shadow_addr_5 = 5'd17;
    set_commit(1'b1, 5'd17, 32'h1234_ABCD);
    #1;
    n_cmp++; if (shadow_data_32 !== 32'd0) begin n_err++; $display("FAIL shadow_nowt: got %h want 0", shadow_data_32); end
    tick();
    set_commit(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    set_commit(1'b0, 5'd0, 32'd0);
    n_cmp++; if (shadow_data_32 !== exp17) begin n_err++; $display("FAIL shadow_r17: got %h want %h", shadow_data_32, exp17); end
    shadow_addr_5 = 5'd0;
    #1;
    n_cmp++; if (shadow_data_32 !== 32'd0) begin n_err++; $display("FAIL shadow_r0: got %h want 0", shadow_data_32); end
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b0;
    shadow_addr_5 = 5'd0;
    set_commit(1'b0, 5'd0, 32'd0);
    test_reset();
    test_single_commit();
    test_zero_write();
    test_overflow();
    test_full_pop_and_reset();
    test_back_to_back();
    test_shadow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_commit_monitor.md
Name: wb_commit_monitor

Overview:
- Observation block downstream of the 5-stage pipeline's writeback stage.
- Captures every architectural register-file commit, stamps it with a cycle count, and buffers it in a FIFO.
- Drains entries to the simulation bench or debug logic over a valid/ready handshake, so register traces come from commits rather than from hierarchical peeks.
- Keeps free-running statistics counters.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
CYC_W, 16, width of cycle counter and timestamp field
CNT_W, 16, width of commit and drop statistics counters

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
wb_reg_write  input  1  writeback RegWrite for the current cycle
wb_write_addr_5  input  5  destination register number
wb_write_data_32  input  32  value written to the register file
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_addr_5  output  5  head entry register number
out_data_32  output  32  head entry data
out_cycle  output  CYC_W  cycle stamp of head entry
cycle_count  output  CYC_W  cycles since reset
commit_count  output  CNT_W  commits accepted into FIFO
drop_count  output  CNT_W  commits lost to overflow
overflow  output  1  sticky; set on first drop
shadow_addr_5  input  5  shadow register-file read address (optional feature)
shadow_data_32  output  32  shadow register-file read data (optional feature)

Behaviour:
- Reset (sync, high):
  - Clears read pointer, write pointer, occupancy, cycle_count, commit_count, drop_count and overflow.
  - out_valid=0; out_addr_5, out_data_32 and out_cycle read 0.
  - FIFO storage contents need not clear.
  - Reset wins over all simultaneous events; a commit in the reset cycle is discarded.
- cycle_count:
  - Increments by 1 every non-reset cycle.
  - Wraps modulo 2^CYC_W.
  - Reads 0 in the first cycle after reset.
- Commit qualification:
  - A commit occurs in a cycle where wb_reg_write=1 and wb_write_addr_5 != 0.
  - Writes to $zero are ignored entirely: no push, no count.
- Push:
  - A qualified commit is written at the posedge as {addr, data, cycle_count value of that cycle}.
  - Latency: sampled at edge N, the entry is visible at the head with out_valid=1 after edge N, when the FIFO was empty.
  - First-word fall-through; the head fields are driven combinationally from storage at the read pointer.
- Pop:
  - Occurs when out_valid=1 and out_ready=1 at the posedge.
  - out_ready while empty has no effect.
- Empty: out_valid=0 and head fields read 0.
- Full (occupancy=DEPTH):
  - Commit with simultaneous pop: both occur, and occupancy is unchanged.
  - Commit without pop: entry dropped; drop_count increments; overflow set to 1 and held until reset.
  - FIFO contents are unchanged by a drop.
- commit_count increments on every accepted push.
- commit_count and drop_count saturate at all-ones and do not wrap.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Occupancy is log2(DEPTH)+1 bits.
- Entries are delivered strictly in commit order.

Optional Feature:
- Macro: WB_COMMIT_MONITOR_SHADOW_EN
- Defined:
  - The block keeps a 32x32 shadow register file, updated on every qualified commit, including dropped ones.
  - Register 0 is always 0.
  - shadow_data_32 is a combinational read of shadow_addr_5 and reflects writes from prior edges only, with no write-through.
  - Reset clears all shadow entries to 0.
- Not defined:
  - No shadow storage is built.
  - shadow_data_32 is tied to 0 and shadow_addr_5 is ignored.

Test Plan:
- Reset, then idle 5 cycles -> out_valid=0, cycle_count=5, all counters 0, overflow=0.
- Commit addr 16, data 0x00000005 at cycle 3, with out_ready=0 -> next cycle out_valid=1, out_addr_5=16, out_data_32=0x00000005, out_cycle=3, commit_count=1.
- Commit with addr 0, data 0xFFFFFFFF -> no push; commit_count unchanged; out_valid stays 0.
- With out_ready=0, commit 9 consecutive times, addrs 8..16 -> first 8 buffered; 9th dropped; drop_count=1; overflow=1. Then drain with out_ready=1 -> addrs 8..15 in order, then out_valid=0.
- Full FIFO, commit plus pop in the same cycle -> drop_count unchanged; occupancy stays 8; new entry emerges last. Assert reset mid-stream -> next cycle out_valid=0 and counters 0, while overflow clears.
- With WB_COMMIT_MONITOR_SHADOW_EN defined, commit addr 17, data 0x1234ABCD -> next cycle shadow_addr_5=17 reads 0x1234ABCD, and shadow_addr_5=0 reads 0. With the macro undefined, shadow_data_32 always reads 0.
